// File: rtl/mire_gen_if.sv
// Wishbone classic bus between the pattern generator and the framebuffer.
// Latency: none, this is wiring only.
// Backpressure: the slave stalls the master by holding ack low.
//
// Signals:
//   cyc, stb       bus tenure / strobe (master)
//   we, sel        write enable, byte selects (master)
//   cti, bte       cycle type / burst type, classic only (master)
//   adr, dat_ms    byte address and write data (master)
//   ack            slave acknowledge (slave)
interface mire_gen_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, cti, bte, adr, dat_ms,
    input  ack
  );

  modport slave (
    input  cyc, stb, we, sel, cti, bte, adr, dat_ms,
    output ack
  );
endinterface

// File: rtl/mire_gen.sv
// Test-pattern generator: writes one HDISP x VDISP frame of 32-bit pixels over Wishbone.
// Latency: first write one cycle after start; one pixel per cycle while ack is held high.
// Backpressure: adr/dat held until ack; cyc dropped for GAP cycles after every BURST writes.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mode, solid_col      pattern select (0 grid, 1 bars, 2 checker, 3 solid) and solid colour
//   start, continuous    start one frame from idle; auto-restart after each frame
//   busy, frame_done     frame in progress; one-cycle pulse on the last pixel's ack
//   frame_cnt            completed frames, wraps
//   wshb                 Wishbone classic master
module mire_gen #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter int          BURST    = 64,
  parameter int          GAP      = 1,
  parameter int          GRID     = 16,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [31:0]       solid_col,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  mire_gen_if.master        wshb
);

  localparam int CW   = 16;
  localparam int BARW = HDISP / 8;
  localparam logic [31:0] WHITE = 32'h00FF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] x, y;
  logic [CW-1:0] bx;          // position inside the current colour bar
  logic [2:0]    bar;         // current colour bar index
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] gap_cnt;
  logic [1:0]    mode_q;
  logic [31:0]   solid_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;

  logic [CW-1:0] nx, ny, nbx;
  logic [2:0]    nbar;
  logic          line_end, last_pix, burst_end, gap_end;

  // Pixel colour. GRID is a power of two, so modulo becomes a mask and the
  // checker parity is the GRID bit of x^y. Bars use the running bar index
  // instead of dividing x by HDISP/8.
  function automatic logic [31:0] pix(input logic [1:0]    m,
                                      input logic [CW-1:0] px,
                                      input logic [CW-1:0] py,
                                      input logic [2:0]    b,
                                      input logic [31:0]   sc);
    logic [31:0] r;
    r = 32'h0;
    case (m)
      2'd0: r = (((px & CW'(GRID - 1)) == '0) || ((py & CW'(GRID - 1)) == '0)) ? WHITE : 32'h0;
      2'd1: begin
        case (b)
          3'd0:    r = 32'h00FF_FFFF;
          3'd1:    r = 32'h00FF_FF00;
          3'd2:    r = 32'h0000_FFFF;
          3'd3:    r = 32'h0000_FF00;
          3'd4:    r = 32'h00FF_00FF;
          3'd5:    r = 32'h00FF_0000;
          3'd6:    r = 32'h0000_00FF;
          default: r = 32'h0000_0000;
        endcase
      end
      2'd2:    r = (((px ^ py) & CW'(GRID)) == '0) ? WHITE : 32'h0;
      default: r = sc;
    endcase
    return r;
  endfunction

  // Position of the pixel that follows the current one in raster order.
  always_comb begin
    line_end  = (x == CW'(HDISP - 1));
    last_pix  = line_end && (y == CW'(VDISP - 1));
    burst_end = (burst_cnt == CW'(BURST - 1));
    gap_end   = (gap_cnt == CW'(GAP - 1));
    nx   = x + CW'(1);
    ny   = y;
    nbx  = bx + CW'(1);
    nbar = bar;
    if (line_end) begin
      nx   = '0;
      nbx  = '0;
      nbar = 3'd0;
      ny   = last_pix ? '0 : y + CW'(1);
    end else if (bx == CW'(BARW - 1)) begin
      nbx  = '0;
      nbar = bar + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_XFER;
      S_XFER: begin
        if (wshb.ack) begin
          // A final ack on a burst boundary still yields a single gap.
          if (last_pix)       state_nxt = continuous ? S_GAP : S_IDLE;
          else if (burst_end) state_nxt = S_GAP;
        end
      end
      S_GAP:   if (gap_end) state_nxt = S_XFER;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      bx         <= '0;
      bar        <= 3'd0;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
      mode_q     <= 2'd0;
      solid_q    <= 32'h0;
      adr_q      <= BASE_ADR;
      dat_q      <= 32'h0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Pattern selection is frozen here for the whole run, including
            // frames that restart automatically in continuous mode.
            mode_q    <= mode;
            solid_q   <= solid_col;
            x         <= '0;
            y         <= '0;
            bx        <= '0;
            bar       <= 3'd0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            adr_q     <= BASE_ADR;
            dat_q     <= pix(mode, '0, '0, 3'd0, solid_col);
          end
        end
        S_XFER: begin
          if (wshb.ack) begin
            x       <= nx;
            y       <= ny;
            bx      <= nbx;
            bar     <= nbar;
            gap_cnt <= '0;
            dat_q   <= pix(mode_q, nx, ny, nbar, solid_q);
            if (last_pix) begin
              adr_q      <= BASE_ADR;
              burst_cnt  <= '0;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end else begin
              // Raster order is contiguous in memory, so the next pixel is
              // always one word further, even across a line end.
              adr_q     <= adr_q + 32'd4;
              burst_cnt <= burst_end ? '0 : burst_cnt + CW'(1);
            end
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + CW'(1);
        default: ;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign wshb.cyc    = (state == S_XFER);
  assign wshb.stb    = (state == S_XFER);
  assign wshb.we     = 1'b1;
  assign wshb.sel    = 4'hF;
  assign wshb.cti    = 3'b000;
  assign wshb.bte    = 2'b00;
  assign wshb.adr    = adr_q;
  assign wshb.dat_ms = dat_q;

endmodule

// File: tb/tb_mire_gen.sv
// Bench for mire_gen: random Wishbone slave, raster-order reference model, frame capture.
// Latency: model tracks the expected bus state cycle by cycle.
// Backpressure: slave ack is tied high, randomly delayed 0-5 cycles, or random noise.
module tb_mire_gen;
  localparam int          HDISP = 64;
  localparam int          VDISP = 24;
  localparam int          BURST = 8;
  localparam int          GAP   = 2;
  localparam int          GRID  = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          NPIX  = HDISP * VDISP;
  localparam int          TMO   = 20000;
  localparam logic [31:0] WHITE = 32'h00FF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [31:0] solid_col = 32'h0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        busy, frame_done;
  logic [15:0] frame_cnt;

  mire_gen_if wshb();

  mire_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .GAP(GAP), .GRID(GRID), .BASE_ADR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .solid_col(solid_col), .start(start),
    .continuous(continuous), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .wshb(wshb)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Expected pixel colour straight from the pattern rules.
  function automatic logic [31:0] ref_pix(int m, int px, int py, logic [31:0] sc);
    if (m == 0) return ((px % GRID == 0) || (py % GRID == 0)) ? WHITE : 32'h0;
    if (m == 1) begin
      case (px / (HDISP / 8))
        0: return 32'h00FF_FFFF;
        1: return 32'h00FF_FF00;
        2: return 32'h0000_FFFF;
        3: return 32'h0000_FF00;
        4: return 32'h00FF_00FF;
        5: return 32'h00FF_0000;
        6: return 32'h0000_00FF;
        default: return 32'h0;
      endcase
    end
    if (m == 2) return ((((px / GRID) ^ (py / GRID)) & 1) == 0) ? WHITE : 32'h0;
    return sc;
  endfunction

  // ---------------- slave ----------------
  int ack_mode = 0;   // 0 tied high, 1 random delay, 2 random noise
  int ack_wait = 0;
  always @(posedge clk) begin
    #1;
    if (ack_mode == 0) wshb.ack = 1'b1;
    else if (ack_mode == 1 && wshb.stb) begin
      if (ack_wait == 0) begin
        wshb.ack = 1'b1;
        ack_wait = $urandom_range(0, 5);
      end else begin
        wshb.ack = 1'b0;
        ack_wait--;
      end
    end else wshb.ack = 1'($urandom_range(0, 1));
  end

  // ---------------- reference model + monitor ----------------
  bit          mon_en = 1'b0;
  bit          m_busy = 1'b0, m_cyc = 1'b0, m_done = 1'b0;
  logic [15:0] m_fcnt = 16'h0;
  int          m_pos = 0, m_ten = 0, m_gap = 0, m_wr = 0, m_mode = 0;
  logic [31:0] m_solid = 32'h0;
  int          dut_wr = 0, dut_done = 0;
  logic [31:0] fb [NPIX];
  logic [31:0] idx;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("cyc", 32'(wshb.cyc), 32'(m_cyc));
      chk("stb", 32'(wshb.stb), 32'(m_cyc));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
      if (m_cyc) begin
        chk("adr", wshb.adr, BASE + 32'(m_pos * 4));
        chk("dat", wshb.dat_ms, ref_pix(m_mode, m_pos % HDISP, m_pos / HDISP, m_solid));
      end
      if (frame_done) dut_done++;
      if (!rst && wshb.stb && wshb.ack) begin
        dut_wr++;
        idx = (wshb.adr - BASE) >> 2;
        if (idx < 32'(NPIX)) fb[idx] = wshb.dat_ms;
      end
      // advance to the state expected after the coming edge
      m_done = 1'b0;
      if (rst) begin
        m_busy = 1'b0; m_cyc = 1'b0; m_fcnt = 16'h0; m_pos = 0; m_ten = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_cyc = 1'b1; m_pos = 0; m_ten = 0;
          m_mode = int'(mode); m_solid = solid_col;
        end
      end else if (m_cyc) begin
        if (wshb.ack) begin
          m_wr++;
          m_ten++;
          if (m_pos == NPIX - 1) begin
            m_done = 1'b1;
            m_fcnt++;
            m_pos = 0;
            m_ten = 0;
            m_cyc = 1'b0;
            if (continuous) m_gap = GAP;
            else m_busy = 1'b0;
          end else begin
            m_pos++;
            if (m_ten == BURST) begin
              m_ten = 0; m_cyc = 1'b0; m_gap = GAP;
            end
          end
        end
      end else begin
        m_gap--;
        if (m_gap == 0) m_cyc = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic go(input logic [1:0] m, input logic [31:0] sc, input logic cont);
    mode = m; solid_col = sc; continuous = cont; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (m_wr < target && n < TMO) begin step(); n++; end
    chk("wr_timeout", 32'(m_wr >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < TMO) begin step(); n++; end
    chk("idle_timeout", 32'(m_busy), 32'd0);
  endtask

  function automatic logic [31:0] fbp(int px, int py);
    return fb[py * HDISP + px];
  endfunction

  int d0, w0, n;
  logic [31:0] sc;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_cyc", 32'(wshb.cyc), 32'd0);
    chk("rst_we", 32'(wshb.we), 32'd1);
    chk("rst_sel", 32'(wshb.sel), 32'hF);
    chk("rst_cti", 32'(wshb.cti), 32'd0);
    chk("rst_bte", 32'(wshb.bte), 32'd0);
    chk("rst_adr", wshb.adr, BASE);
    chk("rst_dat", wshb.dat_ms, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);

    // reset in the middle of a frame
    ack_mode = 1;
    go(2'd0, 32'h0, 1'b0);
    wait_wr(100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_cyc", 32'(wshb.cyc), 32'd0);
    chk("mid_rst_adr", wshb.adr, BASE);
    chk("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    #1;
    rst = 1'b0;
    step();

    // grid, ack tied high
    ack_mode = 0;
    d0 = dut_wr;
    go(2'd0, 32'h0, 1'b0);
    wait_idle();
    step();
    chk("grid_writes", 32'(dut_wr - d0), 32'(NPIX));
    chk("grid_fcnt", 32'(frame_cnt), 32'd1);
    chk("grid_busy", 32'(busy), 32'd0);
    chk("grid_0_0", fbp(0, 0), WHITE);
    chk("grid_1_1", fbp(1, 1), 32'h0);
    chk("grid_16_5", fbp(16, 5), WHITE);
    chk("grid_5_16", fbp(5, 16), WHITE);
    chk("grid_63_23", fbp(63, 23), 32'h0);

    // colour bars, random ack; start held while busy, mode changed mid-frame
    ack_mode = 1;
    d0 = dut_wr;
    w0 = m_wr;
    mode = 2'd1; solid_col = 32'h0; continuous = 1'b0; start = 1'b1;
    step();
    wait_wr(w0 + 500);
    mode = 2'd3;
    solid_col = ($urandom() & 32'h00FF_FFFF) | 32'h1;
    wait_wr(w0 + 1400);
    start = 1'b0;
    wait_idle();
    step();
    chk("bars_writes", 32'(dut_wr - d0), 32'(NPIX));
    chk("bars_fcnt", 32'(frame_cnt), 32'd2);
    chk("bars_7_0", fbp(7, 0), 32'h00FF_FFFF);
    chk("bars_8_0", fbp(8, 0), 32'h00FF_FF00);
    chk("bars_20_3", fbp(20, 3), 32'h0000_FFFF);
    chk("bars_40_10", fbp(40, 10), 32'h00FF_0000);
    chk("bars_63_23", fbp(63, 23), 32'h0);

    // checkerboard, random ack
    go(2'd2, 32'h0, 1'b0);
    wait_idle();
    step();
    chk("chk_fcnt", 32'(frame_cnt), 32'd3);
    chk("chk_15_0", fbp(15, 0), WHITE);
    chk("chk_16_0", fbp(16, 0), 32'h0);
    chk("chk_16_16", fbp(16, 16), WHITE);
    chk("chk_0_16", fbp(0, 16), 32'h0);
    chk("chk_63_23", fbp(63, 23), WHITE);

    // continuous solid colour for three frames
    ack_mode = 0;
    sc = $urandom() & 32'h00FF_FFFF;
    go(2'd3, sc, 1'b1);
    n = 0;
    while (m_fcnt != 16'd5 && n < TMO) begin step(); n++; end
    chk("cont_timeout", 32'(m_fcnt), 32'd5);
    wait_wr(m_wr + 100);
    continuous = 1'b0;
    wait_idle();
    repeat (10) step();
    chk("cont_fcnt", 32'(frame_cnt), 32'd6);
    chk("cont_busy", 32'(busy), 32'd0);
    chk("done_pulses", 32'(dut_done), 32'd6);
    chk("cont_5_5", fbp(5, 5), sc);
    chk("cont_63_23", fbp(63, 23), sc);

    // ack noise while idle: nothing may move
    ack_mode = 2;
    d0 = dut_wr;
    repeat (50) step();
    chk("noise_writes", 32'(dut_wr - d0), 32'd0);
    chk("noise_fcnt", 32'(frame_cnt), 32'd6);
    chk("noise_adr", wshb.adr, BASE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
